// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcode/subcode constants, decoded source/destination
//                record and a small hazard-compare helper used by fr_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Register index width for a 16-entry architectural file
  localparam int REG_W = 4;

  // Major opcodes, ins[15:12]
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SMEM = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_LD   = 4'b0111;
  localparam logic [3:0] OP_VLD  = 4'b1100;
  localparam logic [3:0] OP_VST  = 4'b1101;
  localparam logic [3:0] OP_DOT  = 4'b1110;

  // Subcodes: scalar memory selects ld/st in ins[7:4]; jump conditions
  localparam logic [3:0] SUB_LD  = 4'd0;
  localparam logic [3:0] SUB_ST  = 4'd1;
  localparam logic [3:0] SUB_JZ  = 4'd0;
  localparam logic [3:0] SUB_JNZ = 4'd1;
  localparam logic [3:0] SUB_JS  = 4'd2;
  localparam logic [3:0] SUB_JNS = 4'd3;

  // Decoded register usage of one instruction
  typedef struct packed {
    logic             s1_v;
    logic [REG_W-1:0] s1;
    logic             s2_v;
    logic [REG_W-1:0] s2;
    logic             d_v;
    logic [REG_W-1:0] d;
  } src_dst_t;

  // True when either valid source of sd reads the register held in a valid slot
  function automatic logic slot_hit(input src_dst_t sd,
                                    input logic slot_v,
                                    input logic [REG_W-1:0] slot_r);
    return slot_v && ((sd.s1_v && (sd.s1 == slot_r)) ||
                      (sd.s2_v && (sd.s2 == slot_r)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : fr_decode
//  Description : Combinational register-usage decoder. Maps an instruction
//                word onto its source and destination register fields.
//  Revision    : 1.0 - initial release
// ============================================================================
module fr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] i_ins,
  output src_dst_t    o_sd
);

  logic [3:0] w_op;
  logic [3:0] w_sub;

  assign w_op  = i_ins[15:12];
  assign w_sub = i_ins[7:4];

  // Field extraction per opcode; anything unrecognised uses no registers
  always_comb begin
    o_sd = '0;
    case (w_op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_DOT: begin
        o_sd.s1_v = 1'b1;
        o_sd.s1   = i_ins[11:8];
        o_sd.s2_v = 1'b1;
        o_sd.s2   = i_ins[7:4];
        o_sd.d_v  = 1'b1;
        o_sd.d    = i_ins[3:0];
      end
      OP_JMP: begin
        // condition register and target register, nothing written
        o_sd.s1_v = 1'b1;
        o_sd.s1   = i_ins[11:8];
        o_sd.s2_v = 1'b1;
        o_sd.s2   = i_ins[3:0];
      end
      OP_SMEM: begin
        if (w_sub == SUB_LD) begin
          o_sd.s1_v = 1'b1;
          o_sd.s1   = i_ins[11:8];
          o_sd.d_v  = 1'b1;
          o_sd.d    = i_ins[3:0];
        end else if (w_sub == SUB_ST) begin
          // store data travels on operand 1, address on operand 2
          o_sd.s1_v = 1'b1;
          o_sd.s1   = i_ins[3:0];
          o_sd.s2_v = 1'b1;
          o_sd.s2   = i_ins[11:8];
        end
      end
      OP_LD: begin
        o_sd.s1_v = 1'b1;
        o_sd.s1   = i_ins[11:8];
        o_sd.d_v  = 1'b1;
        o_sd.d    = i_ins[3:0];
      end
      OP_VLD, OP_VST: begin
        o_sd.s1_v = 1'b1;
        o_sd.s1   = i_ins[11:8];
        o_sd.s2_v = 1'b1;
        o_sd.s2   = i_ins[3:0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fr_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fr_stage
//  Description : Fetch-result / register-read stage feeding the two-stage
//                execute ALU. Owns the register file, tracks destinations of
//                the three in-flight slots (fr, x, x2) and stalls on RAW
//                hazards. Execute-2 writeback commits into the file here.
//  Config      : FR_FORWARD_EN - when defined, a hazard against the x2 slot
//                only is resolved by forwarding the writeback value (and any
//                read of the register being written returns wb_data). When
//                undefined, every hazard stalls until the value is committed.
//  Revision    : 1.0 - initial release
// ============================================================================
module fr_stage
  import cpu_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int XLEN  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_ins,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_reg,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             fr_valid,
  output logic [XLEN-1:0]  fr_ins,
  output logic [XLEN-1:0]  fr_pc,
  output logic [XLEN-1:0]  fr_operand_1,
  output logic [XLEN-1:0]  fr_operand_2
);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]  r_rf [NREGS];

  logic             r_fr_valid;
  logic [XLEN-1:0]  r_fr_ins;
  logic [XLEN-1:0]  r_fr_pc;
  logic [XLEN-1:0]  r_fr_op1;
  logic [XLEN-1:0]  r_fr_op2;

  // Destination scoreboard: D1 = fr slot, D2 = x slot, D3 = x2 slot
  logic             r_d1_v;
  logic [REG_W-1:0] r_d1_r;
  logic             r_d2_v;
  logic [REG_W-1:0] r_d2_r;
  logic             r_d3_v;
  logic [REG_W-1:0] r_d3_r;

  // --------------------------------------------------------------------------
  // Decode, hazard detection and operand read
  // --------------------------------------------------------------------------
  src_dst_t         w_sd;
  logic             w_hit1;
  logic             w_hit2;
  logic             w_stall;
  logic             w_capture;
  logic [XLEN-1:0]  w_rd1;
  logic [XLEN-1:0]  w_rd2;

  fr_decode u_decode (
    .i_ins (in_ins),
    .o_sd  (w_sd)
  );

  assign w_hit1 = slot_hit(w_sd, r_d1_v, r_d1_r);
  assign w_hit2 = slot_hit(w_sd, r_d2_v, r_d2_r);

`ifdef FR_FORWARD_EN
  // The x2 slot is the one writing back this cycle, so its value is already
  // on wb_data; only the two younger slots have to wait.
  assign w_stall = w_hit1 | w_hit2;
`else
  logic w_hit3;
  assign w_hit3  = slot_hit(w_sd, r_d3_v, r_d3_r);
  assign w_stall = w_hit1 | w_hit2 | w_hit3;
`endif

  // Reset and flush both refuse input; flush drops it so upstream can refetch
  assign in_ready  = rst_n & ~flush & ~w_stall;
  assign w_capture = in_valid & in_ready;

  // Source operand read, with write-through of a same-cycle commit if enabled
  always_comb begin
    w_rd1 = r_rf[w_sd.s1];
    w_rd2 = r_rf[w_sd.s2];
`ifdef FR_FORWARD_EN
    if (wb_en && (wb_reg == w_sd.s1)) w_rd1 = wb_data;
    if (wb_en && (wb_reg == w_sd.s2)) w_rd2 = wb_data;
`endif
  end

  // --------------------------------------------------------------------------
  // Register file: commit from the end of execute stage 2 (contents not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wb_en) r_rf[wb_reg] <= wb_data;
  end

  // --------------------------------------------------------------------------
  // Issue register and destination scoreboard advance
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fr_valid <= 1'b0;
      r_fr_ins   <= '0;
      r_fr_pc    <= '0;
      r_fr_op1   <= '0;
      r_fr_op2   <= '0;
      r_d1_v     <= 1'b0;
      r_d1_r     <= '0;
      r_d2_v     <= 1'b0;
      r_d2_r     <= '0;
      r_d3_v     <= 1'b0;
      r_d3_r     <= '0;
    end else if (flush) begin
      // Kill the fr and x slots; the x2 entry is older than the jump's
      // consequences and still commits, so its record is left alone.
      r_fr_valid <= 1'b0;
      r_fr_ins   <= '0;
      r_d1_v     <= 1'b0;
      r_d2_v     <= 1'b0;
    end else begin
      r_d3_v <= r_d2_v;
      r_d3_r <= r_d2_r;
      r_d2_v <= r_d1_v;
      r_d2_r <= r_d1_r;
      if (w_capture) begin
        r_fr_valid <= 1'b1;
        r_fr_ins   <= in_ins;
        r_fr_pc    <= in_pc;
        r_fr_op1   <= w_rd1;
        r_fr_op2   <= w_rd2;
        r_d1_v     <= w_sd.d_v;
        r_d1_r     <= w_sd.d;
      end else begin
        // Bubble: pc/operands hold to avoid needless toggling downstream
        r_fr_valid <= 1'b0;
        r_fr_ins   <= '0;
        r_d1_v     <= 1'b0;
      end
    end
  end

  assign fr_valid     = r_fr_valid;
  assign fr_ins       = r_fr_ins;
  assign fr_pc        = r_fr_pc;
  assign fr_operand_1 = r_fr_op1;
  assign fr_operand_2 = r_fr_op2;

endmodule
`default_nettype wire
